// File: rtl/hex_dump_fmt.sv
// Formats raw bytes from a FWFT source as ASCII hex ("XY "), inserting CR LF every
// BYTES_PER_LINE bytes and after an idle timeout on a partially filled line.
module hex_dump_fmt #(
  parameter int BYTES_PER_LINE = 16,
  parameter int IDLE_TIMEOUT   = 1024,
  parameter int UPPER          = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_empty,
  output logic       in_get,
  output logic [7:0] out,
  input  logic       out_get,
  output logic       out_empty,
  output logic [2:0] state_dbg
);

  // Handshake: both sides are FWFT. A byte moves upstream->here in a cycle where
  // in_get=1 (IDLE, in_empty=0); a character moves here->downstream in a cycle
  // where out_get=1 and out_empty=0. out_get while out_empty=1 is ignored.
  typedef enum logic [2:0] {IDLE, HI, LO, SEP, CR, LF} state_t;

  localparam int             IW        = (IDLE_TIMEOUT < 1) ? 1 : $clog2(IDLE_TIMEOUT + 1);
  localparam logic [7:0]     COL_LAST  = 8'(BYTES_PER_LINE - 1);
  localparam logic [IW-1:0]  IDLE_LAST = IW'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);
  localparam logic           FLUSH_EN  = (IDLE_TIMEOUT != 0);

  state_t        state;
  logic [7:0]    byte_r;
  logic [7:0]    col;
  logic [IW-1:0] idle_cnt;
  logic          adv;
  logic          idle_tick;
  logic          flush_hit;

  function automatic logic [7:0] hex(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return ((UPPER != 0) ? 8'h41 : 8'h61) + {4'h0, n} - 8'd10;
  endfunction

  assign in_get    = (state == IDLE) & ~in_empty & reset;
  assign adv       = out_get & ~out_empty;
  assign idle_tick = (state == IDLE) & (col != 8'd0) & in_empty;
  assign flush_hit = FLUSH_EN & idle_tick & (idle_cnt == IDLE_LAST);
  assign state_dbg = state;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      out       <= 8'h00;
      out_empty <= 1'b1;
      byte_r    <= 8'h00;
      col       <= 8'd0;
      idle_cnt  <= '0;
    end else begin
      // Counter runs only while a partial line waits for more input.
      if (idle_tick && !flush_hit) idle_cnt <= idle_cnt + 1'b1;
      else                         idle_cnt <= '0;

      case (state)
        IDLE: begin
          if (!in_empty) begin
            byte_r    <= in_data;
            out       <= hex(in_data[7:4]);
            out_empty <= 1'b0;
            state     <= HI;
          end else if (flush_hit) begin
            out       <= 8'h0D;
            out_empty <= 1'b0;
            col       <= 8'd0;
            state     <= CR;
          end
        end
        HI: if (adv) begin
          out   <= hex(byte_r[3:0]);
          state <= LO;
        end
        LO: if (adv) begin
          if (col == COL_LAST) begin
            out   <= 8'h0D;
            col   <= 8'd0;
            state <= CR;
          end else begin
            out   <= 8'h20;
            col   <= col + 8'd1;
            state <= SEP;
          end
        end
        SEP: if (adv) begin
          out_empty <= 1'b1;
          state     <= IDLE;
        end
        CR: if (adv) begin
          out   <= 8'h0A;
          state <= LF;
        end
        LF: if (adv) begin
          out_empty <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          out_empty <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
